instruction_stream_sequencer: RTL and testbench
===============================================

Name: instruction_stream_sequencer

Overview:
- Synthesizable program sequencer that supersedes the bench-side `$readmemh` loop feeding `tensor_core_controller`.
- Holds a loadable program memory and streams instructions to the controller's `current_instruction` input under a valid/ready handshake.
- Supports run, repeat and single-step modes, plus halt-word detection.
- Sits between the host load path and `tensor_core_controller`.

Parameters:
- INSTRUCTION_WIDTH, 16, bits per instruction word.
- PROGRAM_DEPTH, 1024, number of program memory entries.
- ADDRESS_WIDTH, $clog2(PROGRAM_DEPTH), program counter and address width.
- HALT_INSTRUCTION, 16'hFFFF, full-word match that terminates the program.
- NOP_INSTRUCTION, 16'h0000, value driven on current_instruction whenever instruction_valid is 0.

Ports:
- clock_in  input  1  single system clock; all logic on posedge.
- reset_in  input  1  asynchronous, active-high reset.
- load_enable  input  1  program memory write strobe.
- load_address  input  ADDRESS_WIDTH  write address.
- load_data  input  INSTRUCTION_WIDTH  write data.
- program_length  input  ADDRESS_WIDTH+1  number of instructions per pass (0..PROGRAM_DEPTH).
- repeat_count  input  8  extra passes; total passes = repeat_count+1.
- start  input  1  begin run-mode execution from address 0.
- step  input  1  issue exactly one instruction at the current PC.
- abort  input  1  cancel execution.
- consumer_ready  input  1  controller accepts current_instruction this cycle.
- current_instruction  output  INSTRUCTION_WIDTH  instruction presented to the controller.
- instruction_valid  output  1  current_instruction is valid.
- program_counter  output  ADDRESS_WIDTH  address of the presented or next instruction.
- busy  output  1  high in FETCH and ISSUE.
- done  output  1  one-cycle completion pulse.
- halted_by_instruction  output  1  last completion was caused by HALT_INSTRUCTION.
- issued_count  output  32  handshakes completed since the last start; saturates at all-ones.

Behaviour:
- Reset, async, active-high:
  - State → IDLE; PC = 0; pass counter = 0; issued_count = 0.
  - instruction_valid = 0; done = 0; halted_by_instruction = 0; busy = 0.
  - current_instruction = NOP_INSTRUCTION.
  - Memory contents are not reset.
- Memory:
  - Synchronous write and synchronous read, 1-cycle read latency.
  - Writes are accepted only when busy = 0; ignored while busy.
  - Addresses >= PROGRAM_DEPTH are ignored.
- States: IDLE, FETCH, ISSUE, PAUSED, DONE.
- IDLE / PAUSED:
  - start: PC ← 0, pass ← 0, issued_count ← 0, halted_by_instruction ← 0, mode = run, → FETCH.
  - If start and program_length == 0: → DONE instead.
  - step: mode = step, PC unchanged, → FETCH.
  - If PC >= program_length on step: → DONE.
  - start and step together: start wins.
  - start or step while busy: ignored.
- FETCH (one cycle):
  - Memory is read at PC.
  - If the read word == HALT_INSTRUCTION: → DONE, halted_by_instruction ← 1, valid never asserted for it.
  - Otherwise → ISSUE with instruction_valid = 1.
  - Latency: start sampled at cycle N → valid first high at cycle N+2.
- ISSUE:
  - While valid && !consumer_ready, current_instruction and PC hold stable.
  - On handshake (valid && ready): issued_count += 1 (saturating).
  - Run mode: the next word is fetched in the same cycle, giving sustained 1 instruction/cycle while ready is high.
  - If the handshaked PC == program_length-1 and pass < repeat_count: PC ← 0, pass += 1.
  - If the handshaked PC == program_length-1 and pass == repeat_count: valid ← 0, → DONE.
  - A HALT word fetched back-to-back drops valid and → DONE with halted_by_instruction = 1.
  - Step mode: after the handshake, PC += 1, valid ← 0, → PAUSED.
- DONE: done = 1 for exactly one cycle, → IDLE. PC retains its final value.
- abort, any state, highest priority after reset:
  - Next cycle: → IDLE, valid = 0, PC = 0, no done pulse.
  - issued_count is held.
- Whenever valid = 0, current_instruction = NOP_INSTRUCTION.

Test Plan:
1. Basic run:
   - Stimulus: load 0x1234, 0x5678, 0x9ABC at addresses 0-2; length = 3; repeat = 0; ready = 1; start pulse at cycle N.
   - Required: words on cycles N+2, N+3, N+4; done at N+5; issued_count = 3; halted_by_instruction = 0.
2. Backpressure:
   - Stimulus: same program; ready low for 4 cycles while 0x5678 is presented.
   - Required: 0x5678 held stable with PC = 1; no skipped or duplicated words; issued_count = 3.
3. Repeat:
   - Stimulus: repeat_count = 2.
   - Required: 9 handshakes in the order 1234, 5678, 9ABC ×3; single done pulse; issued_count = 9.
4. Halt:
   - Stimulus: address 1 = 0xFFFF; length = 3.
   - Required: only 0x1234 issued; done pulse; halted_by_instruction = 1; issued_count = 1; NOP driven afterwards.
5. Step mode:
   - Stimulus: after reset, three step pulses spaced 5 cycles apart.
   - Required: exactly one instruction per pulse; PC reads 1, 2, 3 in PAUSED; a fourth step pulse produces done.
6. Abort / reset:
   - Stimulus: abort mid-run, then a new start.
   - Required: abort → valid = 0, PC = 0, no done pulse; the new start runs from 0x1234.
   - Stimulus: async reset_in asserted mid-ISSUE.
   - Required: outputs clear immediately without waiting for a clock edge; memory is preserved, and a rerun after reset gives the same words.

Source files
------------

// File: rtl/instruction_stream_sequencer_if.sv
// Host/controller-facing bundle for the instruction stream sequencer.
// Carries program load, run control, the instruction stream and status.
// master = host/controller side, slave = sequencer side.
interface instruction_stream_sequencer_if #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH     = 10
);
    logic                         load_enable;
    logic [ADDRESS_WIDTH-1:0]     load_address;
    logic [INSTRUCTION_WIDTH-1:0] load_data;
    logic [ADDRESS_WIDTH:0]       program_length;
    logic [7:0]                   repeat_count;
    logic                         start;
    logic                         step;
    logic                         abort;
    logic                         consumer_ready;
    logic [INSTRUCTION_WIDTH-1:0] current_instruction;
    logic                         instruction_valid;
    logic [ADDRESS_WIDTH-1:0]     program_counter;
    logic                         busy;
    logic                         done;
    logic                         halted_by_instruction;
    logic [31:0]                  issued_count;

    modport master (
        output load_enable, load_address, load_data, program_length, repeat_count,
               start, step, abort, consumer_ready,
        input  current_instruction, instruction_valid, program_counter, busy,
               done, halted_by_instruction, issued_count
    );

    modport slave (
        input  load_enable, load_address, load_data, program_length, repeat_count,
               start, step, abort, consumer_ready,
        output current_instruction, instruction_valid, program_counter, busy,
               done, halted_by_instruction, issued_count
    );
endinterface

// File: rtl/instruction_stream_sequencer.sv
// Program memory plus sequencer streaming instructions to the tensor core controller.
// Latency: start sampled at cycle N -> first valid at N+2; then 1 instruction/cycle.
// Backpressure: word and PC hold while valid && !consumer_ready; next word is prefetched.
module instruction_stream_sequencer #(
    parameter int                           INSTRUCTION_WIDTH = 16,
    parameter int                           PROGRAM_DEPTH     = 1024,
    parameter int                           ADDRESS_WIDTH     = $clog2(PROGRAM_DEPTH),
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION  = 16'hFFFF,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = 16'h0000
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    instruction_stream_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(PROGRAM_DEPTH);

    logic [INSTRUCTION_WIDTH-1:0] mem_q [PROGRAM_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] rdata_q;
    logic [ADDRESS_WIDTH-1:0]     raddr;
    logic                         wr_en;

    logic [2:0]                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
    logic [7:0]                   pass_q, pass_d;
    logic [31:0]                  count_q, count_d;
    logic                         valid_q, valid_d;
    logic [INSTRUCTION_WIDTH-1:0] cur_q, cur_d;
    logic                         halted_q, halted_d;
    logic                         run_mode_q, run_mode_d;

    logic                         busy;
    logic                         handshake;
    logic [ADDRESS_WIDTH:0]       len_m1;
    logic                         last_in_pass;
    logic                         raddr_last;

    assign busy         = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign handshake    = valid_q && bus.consumer_ready;
    assign len_m1       = bus.program_length - 1'b1;
    assign last_in_pass = ({1'b0, pc_q} == len_m1);
    assign raddr_last   = ({1'b0, pc_d} == len_m1);
    assign wr_en        = bus.load_enable && !busy && ({1'b0, bus.load_address} < DEPTH_W);

    // Sequencing decisions: mode entry, fetch/halt check, issue handshake, abort override.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pass_d     = pass_q;
        count_d    = count_q;
        valid_d    = valid_q;
        cur_d      = cur_q;
        halted_d   = halted_q;
        run_mode_d = run_mode_q;
        case (state_q)
            S_IDLE, S_PAUSED: begin
                if (bus.start) begin
                    pc_d       = '0;
                    pass_d     = '0;
                    count_d    = '0;
                    halted_d   = 1'b0;
                    run_mode_d = 1'b1;
                    state_d    = (bus.program_length == '0) ? S_DONE : S_FETCH;
                end else if (bus.step) begin
                    run_mode_d = 1'b0;
                    state_d    = ({1'b0, pc_q} >= bus.program_length) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rdata_q == HALT_INSTRUCTION) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    valid_d = 1'b1;
                    cur_d   = rdata_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    count_d = (count_q == '1) ? count_q : count_q + 32'd1;
                    if (!run_mode_q) begin
                        pc_d    = pc_q + 1'b1;
                        valid_d = 1'b0;
                        cur_d   = NOP_INSTRUCTION;
                        state_d = S_PAUSED;
                    end else if (last_in_pass && (pass_q == bus.repeat_count)) begin
                        valid_d = 1'b0;
                        cur_d   = NOP_INSTRUCTION;
                        state_d = S_DONE;
                    end else begin
                        // rdata_q already holds the prefetched word at the next address
                        pc_d = last_in_pass ? '0 : pc_q + 1'b1;
                        if (last_in_pass) begin
                            pass_d = pass_q + 8'd1;
                        end
                        if (rdata_q == HALT_INSTRUCTION) begin
                            valid_d  = 1'b0;
                            cur_d    = NOP_INSTRUCTION;
                            halted_d = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            cur_d = rdata_q;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            pc_d    = '0;
            valid_d = 1'b0;
            cur_d   = NOP_INSTRUCTION;
            count_d = count_q;
            pass_d  = pass_q;
        end
    end

    // Read address: in ISSUE prefetch the word after the one being presented, else read at PC.
    always_comb begin
        raddr = pc_d;
        if (state_d == S_ISSUE) begin
            raddr = raddr_last ? '0 : pc_d + 1'b1;
        end
    end

    // Program memory: synchronous write when idle, synchronous read with same-address forwarding.
    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem_q[bus.load_address] <= bus.load_data;
        end
        rdata_q <= (wr_en && (bus.load_address == raddr)) ? bus.load_data : mem_q[raddr];
    end

    // Sequencer state registers.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            pass_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            cur_q      <= NOP_INSTRUCTION;
            halted_q   <= 1'b0;
            run_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pass_q     <= pass_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            cur_q      <= cur_d;
            halted_q   <= halted_d;
            run_mode_q <= run_mode_d;
        end
    end

    assign bus.current_instruction   = cur_q;
    assign bus.instruction_valid     = valid_q;
    assign bus.program_counter       = pc_q;
    assign bus.busy                  = busy;
    assign bus.done                  = (state_q == S_DONE);
    assign bus.halted_by_instruction = halted_q;
    assign bus.issued_count          = count_q;
endmodule

// File: tb/tb_instruction_stream_sequencer.sv
// Testbench for instruction_stream_sequencer: directed scenarios plus randomized programs.
// Expected streams come from a pass/word-level model of the program semantics.
module tb_instruction_stream_sequencer;
    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    instruction_stream_sequencer_if bus ();
    instruction_stream_sequencer dut (.clock_in(clk), .reset_in(reset_in), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_hs = -1;
    int done_edge = -1;
    int done_cnt = 0;
    int stall5678 = 0;
    int ready_mode = 0;
    int stall_left = 0;
    bit mon_on = 1'b0;
    bit stall_prev = 1'b0;
    logic [15:0] prev_word = '0;
    logic [9:0]  prev_pc = '0;
    logic [15:0] prog [1024];
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    bit exp_halt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Consumer-ready driver: always ready, random, or a 4-cycle stall on 0x5678.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.consumer_ready = 1'b1;
            1: bus.consumer_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.instruction_valid && bus.current_instruction == 16'h5678 && stall_left > 0) begin
                    bus.consumer_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.consumer_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: record handshakes and done pulses, check NOP-when-idle and hold-under-stall.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!bus.instruction_valid) chk("nop_when_invalid", 32'(bus.current_instruction), 32'h0);
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.instruction_valid), 32'h1);
                chk("hold_word", 32'(bus.current_instruction), 32'(prev_word));
                chk("hold_pc", 32'(bus.program_counter), 32'(prev_pc));
            end
            if (bus.instruction_valid && bus.consumer_ready && !bus.abort) begin
                got_q.push_back(bus.current_instruction);
                if (first_hs < 0) first_hs = cyc + 1;
            end
            if (bus.instruction_valid && !bus.consumer_ready &&
                bus.current_instruction == 16'h5678 && bus.program_counter == 10'd1) stall5678++;
            if (bus.done) begin
                done_cnt++;
                done_edge = cyc + 1;
            end
        end
        stall_prev = mon_on && bus.instruction_valid && !bus.consumer_ready && !bus.abort;
        prev_word  = bus.current_instruction;
        prev_pc    = bus.program_counter;
    end

    task automatic load_word(input int addr, input logic [15:0] data, input bit shadow);
        @(posedge clk); #1;
        bus.load_enable  = 1'b1;
        bus.load_address = 10'(addr);
        bus.load_data    = data;
        if (shadow) prog[addr] = data;
        @(posedge clk); #1;
        bus.load_enable = 1'b0;
    endtask

    task automatic load_basic();
        load_word(0, 16'h1234, 1'b1);
        load_word(1, 16'h5678, 1'b1);
        load_word(2, 16'h9ABC, 1'b1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 bus.step = 1'b1;
        @(posedge clk); #1 bus.step = 1'b0;
    endtask

    task automatic clear_mon();
        got_q.delete();
        first_hs  = -1;
        done_edge = -1;
        done_cnt  = 0;
        stall5678 = 0;
    endtask

    // Reference: walk passes and words; a halt word ends the program without being issued.
    task automatic build_expected(input int len, input int rpt);
        exp_q.delete();
        exp_halt = 1'b0;
        for (int p = 0; p <= rpt && !exp_halt; p++)
            for (int i = 0; i < len && !exp_halt; i++)
                if (prog[i] == 16'hFFFF) exp_halt = 1'b1;
                else exp_q.push_back(prog[i]);
    endtask

    task automatic run_prog(input string tag, input int len, input int rpt, input bit timing, input bit poke);
        bus.program_length = 11'(len);
        bus.repeat_count   = 8'(rpt);
        clear_mon();
        build_expected(len, rpt);
        pulse_start();
        if (poke) load_word(0, 16'hDEAD, 1'b0);
        for (int t = 0; t < 3000 && done_cnt == 0; t++) @(posedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'h1);
        chk({tag, "_halted"}, 32'(bus.halted_by_instruction), 32'(exp_halt));
        chk({tag, "_issued"}, bus.issued_count, 32'(exp_q.size()));
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'h0);
        chk({tag, "_nop_after"}, 32'(bus.current_instruction), 32'h0);
        if (timing) begin
            if (len == 0) chk({tag, "_done_edge"}, 32'(done_edge), 32'(start_cyc + 1));
            else          chk({tag, "_done_edge"}, 32'(done_edge), 32'(start_cyc + 2 + exp_q.size()));
            if (exp_q.size() > 0) chk({tag, "_first_edge"}, 32'(first_hs), 32'(start_cyc + 2));
        end
    endtask

    initial begin
        reset_in = 1'b1;
        bus.load_enable = 1'b0; bus.load_address = '0; bus.load_data = '0;
        bus.program_length = '0; bus.repeat_count = '0;
        bus.start = 1'b0; bus.step = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < 1024; i++) prog[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.instruction_valid), 32'h0);
        chk("rst_instr", 32'(bus.current_instruction), 32'h0);
        chk("rst_pc", 32'(bus.program_counter), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_halted", 32'(bus.halted_by_instruction), 32'h0);
        chk("rst_issued", bus.issued_count, 32'h0);
        reset_in = 1'b0;
        mon_on = 1'b1;

        load_basic();
        run_prog("basic", 3, 0, 1'b1, 1'b0);

        ready_mode = 2; stall_left = 4;
        run_prog("bp", 3, 0, 1'b0, 1'b0);
        chk("bp_stall_cycles", 32'(stall5678), 32'h4);
        ready_mode = 0;

        run_prog("repeat", 3, 2, 1'b1, 1'b1);

        load_word(1, 16'hFFFF, 1'b1);
        run_prog("halt", 3, 0, 1'b1, 1'b0);
        load_word(1, 16'h5678, 1'b1);

        // Step mode from a fresh reset.
        @(posedge clk); #1 reset_in = 1'b1;
        @(posedge clk); #1 reset_in = 1'b0;
        bus.program_length = 11'd3; bus.repeat_count = 8'd0;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            repeat (5) @(posedge clk);
            #1;
            chk("step_count", 32'(got_q.size()), 32'(k + 1));
            if (got_q.size() == k + 1) chk("step_word", 32'(got_q[k]), 32'(prog[k]));
            chk("step_pc", 32'(bus.program_counter), 32'(k + 1));
            chk("step_paused_valid", 32'(bus.instruction_valid), 32'h0);
            chk("step_paused_busy", 32'(bus.busy), 32'h0);
        end
        chk("step_no_done_yet", 32'(done_cnt), 32'h0);
        pulse_step();
        repeat (5) @(posedge clk);
        #1;
        chk("step_final_done", 32'(done_cnt), 32'h1);
        chk("step_final_count", 32'(got_q.size()), 32'h3);
        chk("step_issued", bus.issued_count, 32'h3);

        // Abort mid-run, then a clean restart.
        bus.program_length = 11'd3; bus.repeat_count = 8'd20;
        clear_mon();
        pulse_start();
        repeat (7) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.instruction_valid), 32'h0);
        chk("abort_pc", 32'(bus.program_counter), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'h0);
        chk("abort_issued_held", bus.issued_count, 32'(got_q.size()));
        run_prog("after_abort", 3, 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of ISSUE.
        bus.program_length = 11'd3; bus.repeat_count = 8'd10;
        pulse_start();
        repeat (5) @(posedge clk);
        mon_on = 1'b0;
        #3 reset_in = 1'b1;
        #1;
        chk("areset_valid", 32'(bus.instruction_valid), 32'h0);
        chk("areset_instr", 32'(bus.current_instruction), 32'h0);
        chk("areset_pc", 32'(bus.program_counter), 32'h0);
        chk("areset_busy", 32'(bus.busy), 32'h0);
        chk("areset_issued", bus.issued_count, 32'h0);
        @(posedge clk); #1 reset_in = 1'b0;
        @(posedge clk); #1 mon_on = 1'b1;
        run_prog("after_reset", 3, 0, 1'b1, 1'b0);

        // Randomized programs with occasional halt words and random backpressure.
        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(1, 8);
            int rpt = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                logic [15:0] w;
                w = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
                load_word(i, w, 1'b1);
            end
            ready_mode = it % 2;
            run_prog("rand", len, rpt, (it % 2) == 0, 1'b0);
        end
        ready_mode = 0;
        run_prog("len0", 0, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
